// File: rtl/itof_pipe.sv
// itof_pipe: two-stage pipelined 32-bit integer to IEEE-754 single conversion.
// Stage 1 takes the sign, the magnitude and the leading-zero count.
// Stage 2 normalises, rounds to nearest even and packs the result.
// Both stages use a valid/ready skid-free pipeline, so a stalled consumer
// back-pressures the producer without losing or duplicating data.
module itof_pipe #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
);

  // Exponent of 2^31 in biased form (127 + 31). A normalised value with lz
  // leading zeros has biased exponent EXP_BASE - lz.
  localparam logic [8:0] EXP_BASE = 9'd158;

  // Leading-zero count of a 32-bit word; returns 32 for an all-zero word.
  function automatic logic [5:0] lzc32(input logic [31:0] v);
    logic [5:0] cnt;
    logic       found;
    cnt   = 6'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) begin
          found = 1'b1;
        end else begin
          cnt = cnt + 6'd1;
        end
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  // Round-to-nearest-even decision from guard, sticky and the kept LSB.
  function automatic logic rne_up(input logic guard, input logic sticky,
                                  input logic lsb);
    return guard & (sticky | lsb);
  endfunction

  // Pipeline control
  logic        adv1_s;
  logic        adv2_s;

  // Stage 1 state and its combinational inputs
  logic        v1_q;
  logic        s_q;
  logic [31:0] a_q;
  logic [5:0]  lz_q;
  logic        v1_d;
  logic        s_d;
  logic [31:0] a_d;
  logic [5:0]  lz_d;
  logic        ld1_data_s;

  // Stage 2 state and its combinational inputs
  logic        v2_q;
  logic [31:0] y_q;
  logic        v2_d;
  logic [31:0] y_d;
  logic        ld2_data_s;

  // Stage 2 datapath intermediates
  logic [31:0] n_s;
  logic [23:0] mc_s;
  logic        g_s;
  logic        st_s;
  logic        ru_s;
  logic [24:0] mr_s;
  logic [8:0]  exp_s;
  logic [22:0] man_s;

  // Advance conditions: a stage moves when it is empty or the next one moves.
  always_comb begin
    adv2_s   = ~v2_q | out_ready;
    adv1_s   = ~v1_q | adv2_s;
    in_ready = adv1_s;
  end

  // Stage 1 datapath: sign, magnitude (0x80000000 maps to itself) and lzc.
  always_comb begin
    s_d = SIGNED & x[31];
    if (s_d) begin
      a_d = ~x + 32'd1;
    end else begin
      a_d = x;
    end
    lz_d       = lzc32(a_d);
    v1_d       = in_valid;
    ld1_data_s = adv1_s & in_valid;
  end

  // Stage 1 registers: valid follows in_valid on every advance; data only
  // loads for a real input so y stays zero until the first result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q <= 1'b0;
      s_q  <= 1'b0;
      a_q  <= 32'd0;
      lz_q <= 6'd0;
    end else begin
      if (adv1_s) begin
        v1_q <= v1_d;
      end else begin
        v1_q <= v1_q;
      end
      if (ld1_data_s) begin
        s_q  <= s_d;
        a_q  <= a_d;
        lz_q <= lz_d;
      end else begin
        s_q  <= s_q;
        a_q  <= a_q;
        lz_q <= lz_q;
      end
    end
  end

  // Stage 2 datapath: normalise, round to nearest even, pack the float.
  always_comb begin
    n_s  = a_q << lz_q;
    mc_s = n_s[31:8];
    g_s  = n_s[7];
    st_s = |n_s[6:0];
    ru_s = rne_up(g_s, st_s, mc_s[0]);
    mr_s = {1'b0, mc_s} + {24'd0, ru_s};
    if (mr_s[24]) begin
      // Rounding carried out of the mantissa: value is the next power of two.
      exp_s = EXP_BASE - {3'd0, lz_q} + 9'd1;
      man_s = 23'd0;
    end else begin
      exp_s = EXP_BASE - {3'd0, lz_q};
      man_s = mr_s[22:0];
    end
    if (a_q == 32'd0) begin
      y_d = 32'd0;
    end else begin
      y_d = {s_q, exp_s[7:0], man_s};
    end
    v2_d       = v1_q;
    ld2_data_s = adv2_s & v1_q;
  end

  // Stage 2 registers: hold while the consumer stalls a valid result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q <= 1'b0;
      y_q  <= 32'd0;
    end else begin
      if (adv2_s) begin
        v2_q <= v2_d;
      end else begin
        v2_q <= v2_q;
      end
      if (ld2_data_s) begin
        y_q <= y_d;
      end else begin
        y_q <= y_q;
      end
    end
  end

  // Registered outputs
  always_comb begin
    y         = y_q;
    out_valid = v2_q;
  end

endmodule
